seq_detector_param: RTL and testbench

//  Runtime-programmable serial pattern detector; parametrised successor of the fixed 4-bit Moore detector.

---
 rtl/seq_det_pkg.sv | 27 ++
 rtl/seq_detector_param_sat_counter.sv | 20 ++
 rtl/seq_detector_param.sv | 99 +++++++++
 tb/tb_seq_detector_param.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the programmable serial pattern detector:
// FSM state encoding plus pattern-length helpers.
package seq_det_pkg;

   localparam int MASK_W = 64;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_HUNT  = 2'd1,
      ST_MATCH = 2'd2
   } state_t;

   // Low `len` bits set; callers truncate to their own pattern width.
   function automatic logic [MASK_W-1:0] len_mask(input int len);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int i = 0; i < MASK_W; i++) begin
         m[i] = (i < len);
      end
      return m;
   endfunction

   function automatic int clamp_len(input int cfg_len, input int max_len);
      return ((cfg_len == 0) || (cfg_len > max_len)) ? max_len : cfg_len;
   endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter; clear wins over a simultaneous increment.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with Moore detect pulse,
// overlap/non-overlap modes and a saturating match counter.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int LEN_W   = 5,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               data_in,
   input  logic               cnt_clr,
   output logic               det,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               busy
);

   state_t             state;
   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] hist_next;
   logic [MAX_LEN-1:0] pat_q;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   fill;
   logic [LEN_W-1:0]   fill_next;
   logic               ovl_q;
   logic               accept;
   logic               hit;

   always_comb begin
      accept    = (state != ST_OFF) && en && in_valid && !cfg_load;
      hist_next = hist;
      fill_next = fill;
      if (accept) begin
         hist_next = {hist[MAX_LEN-2:0], data_in};
         fill_next = (fill >= len_q) ? len_q : fill + LEN_W'(1);
      end
      mask = MAX_LEN'(len_mask(32'(len_q)));
      hit  = accept && (fill_next >= len_q) && (((hist_next ^ pat_q) & mask) == '0);
   end

   // cfg_load outranks en so a reload while disabled still updates config.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_OFF;
         hist  <= '0;
         fill  <= '0;
         pat_q <= '0;
         len_q <= LEN_W'(MAX_LEN);
         ovl_q <= 1'b0;
      end else if (cfg_load) begin
         pat_q <= cfg_pattern;
         len_q <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
         ovl_q <= cfg_overlap;
         hist  <= '0;
         fill  <= '0;
         state <= en ? ST_HUNT : ST_OFF;
      end else if (!en) begin
         state <= ST_OFF;
         hist  <= '0;
         fill  <= '0;
      end else begin
         case (state)
            ST_OFF: begin
               state <= ST_HUNT;
               hist  <= '0;
               fill  <= '0;
            end
            default: begin
               hist  <= hist_next;
               // Non-overlap mode needs a fresh window of len bits after a hit.
               fill  <= (hit && !ovl_q) ? '0 : fill_next;
               state <= hit ? ST_MATCH : ST_HUNT;
            end
         endcase
      end
   end

   assign det  = (state == ST_MATCH);
   assign busy = (state != ST_OFF);

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (hit),
      .clr (cnt_clr),
      .q   (match_cnt)
   );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed plus randomized bench for seq_detector_param against a bit-queue reference model.
module tb_seq_detector_param;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 2;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en = 1'b0;
   logic               cfg_load = 1'b0;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [LEN_W-1:0]   cfg_len = '0;
   logic               cfg_overlap = 1'b0;
   logic               in_valid = 1'b0;
   logic               data_in = 1'b0;
   logic               cnt_clr = 1'b0;
   logic               det;
   logic [CNT_W-1:0]   match_cnt;
   logic               busy;

   int ncmp = 0;
   int nfail = 0;

   // Reference model: received bits since last restart, checked by plain comparison.
   bit               mq[$];
   bit               m_on;
   bit [MAX_LEN-1:0] m_pat;
   int               m_len;
   bit               m_ovl;
   int               m_cnt;
   bit               m_det;

   seq_detector_param #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .in_valid    (in_valid),
      .data_in     (data_in),
      .cnt_clr     (cnt_clr),
      .det         (det),
      .match_cnt   (match_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      ncmp++;
      assert (act === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic model_edge();
      bit acc;
      bit hit;
      int l;
      hit = 1'b0;
      if (rst) begin
         mq.delete();
         m_on  = 1'b0;
         m_pat = '0;
         m_len = MAX_LEN;
         m_ovl = 1'b0;
         m_cnt = 0;
      end else begin
         acc = m_on && en && in_valid && !cfg_load;
         if (acc) begin
            mq.push_back(data_in);
            if (mq.size() >= m_len) begin
               hit = 1'b1;
               for (int i = 0; i < m_len; i++) begin
                  if (mq[mq.size()-1-i] != m_pat[i]) hit = 1'b0;
               end
            end
            if (hit && !m_ovl) mq.delete();
         end
         if (cfg_load) begin
            l = int'(cfg_len);
            if (l == 0 || l > MAX_LEN) l = MAX_LEN;
            m_pat = cfg_pattern;
            m_len = l;
            m_ovl = cfg_overlap;
            mq.delete();
            m_on = en;
         end else if (!en) begin
            m_on = 1'b0;
            mq.delete();
         end else if (!m_on) begin
            m_on = 1'b1;
            mq.delete();
         end
         if (cnt_clr) m_cnt = 0;
         else if (hit && m_cnt < (2**CNT_W - 1)) m_cnt++;
      end
      m_det = hit;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("det", 8'(det), 8'(m_det));
      chk("match_cnt", 8'(match_cnt), 8'(m_cnt));
      chk("busy", 8'(busy), 8'(m_on));
   endtask

   task automatic send(input bit b);
      in_valid = 1'b1;
      data_in  = b;
      tick();
      in_valid = 1'b0;
      data_in  = 1'b0;
   endtask

   task automatic load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l, input bit o);
      cfg_load    = 1'b1;
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = o;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic clear_cnt();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
   endtask

   initial begin
      // 1: reset values, then basic 1011 detection
      tick();
      tick();
      chk("rst_det", 8'(det), 8'd0);
      chk("rst_cnt", 8'(match_cnt), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      rst = 1'b0;
      en  = 1'b1;
      load(8'b1011, 4'd4, 1'b0);
      chk("t1_busy", 8'(busy), 8'd1);
      send(1); send(0); send(1);
      chk("t1_nodet", 8'(det), 8'd0);
      send(1);
      chk("t1_det", 8'(det), 8'd1);
      chk("t1_cnt", 8'(match_cnt), 8'd1);
      tick();
      chk("t1_pulse_end", 8'(det), 8'd0);

      // 2: 101 on 10101, overlap then non-overlap
      clear_cnt();
      load(8'b101, 4'd3, 1'b1);
      send(1); send(0); send(1);
      chk("t2_det_a", 8'(det), 8'd1);
      send(0);
      chk("t2_gap", 8'(det), 8'd0);
      send(1);
      chk("t2_det_b", 8'(det), 8'd1);
      chk("t2_cnt_ovl", 8'(match_cnt), 8'd2);
      clear_cnt();
      load(8'b101, 4'd3, 1'b0);
      send(1); send(0); send(1); send(0); send(1);
      chk("t2_cnt_novl", 8'(match_cnt), 8'd1);

      // 3: 1011 with idle gaps of 3 cycles
      clear_cnt();
      load(8'b1011, 4'd4, 1'b0);
      send(1); tick(); tick(); tick();
      send(0); tick(); tick(); tick();
      send(1); tick(); tick(); tick();
      send(1);
      chk("t3_det", 8'(det), 8'd1);
      tick();
      chk("t3_no_stretch", 8'(det), 8'd0);
      chk("t3_cnt", 8'(match_cnt), 8'd1);

      // 4: reload mid-pattern
      clear_cnt();
      load(8'b1011, 4'd4, 1'b0);
      send(1); send(0); send(1);
      load(8'b0110, 4'd4, 1'b0);
      send(1);
      chk("t4_old_lost", 8'(det), 8'd0);
      send(0); send(1); send(1); send(0);
      chk("t4_new_det", 8'(det), 8'd1);
      chk("t4_cnt", 8'(match_cnt), 8'd1);

      // 5: saturation and clear priority
      clear_cnt();
      load(8'b11, 4'd2, 1'b1);
      for (int i = 0; i < 6; i++) send(1);
      chk("t5_sat", 8'(match_cnt), 8'd3);
      cnt_clr = 1'b1;
      send(1);
      cnt_clr = 1'b0;
      chk("t5_clr_hit_det", 8'(det), 8'd1);
      chk("t5_clr_hit_cnt", 8'(match_cnt), 8'd0);

      // 6: disable and reset mid-pattern
      load(8'b1011, 4'd4, 1'b0);
      send(1); send(0); send(1);
      en = 1'b0;
      tick();
      chk("t6_off", 8'(busy), 8'd0);
      en = 1'b1;
      tick();
      send(1);
      chk("t6_no_det", 8'(det), 8'd0);
      send(1); send(0); send(1);
      rst = 1'b1;
      tick();
      chk("t6_rst_det", 8'(det), 8'd0);
      chk("t6_rst_cnt", 8'(match_cnt), 8'd0);
      chk("t6_rst_busy", 8'(busy), 8'd0);
      rst = 1'b0;
      tick();
      send(1);
      chk("t6_fresh", 8'(det), 8'd0);

      // Length clamping: 0 and >MAX_LEN both mean MAX_LEN
      load(8'hA5, 4'd0, 1'b0);
      for (int i = 7; i >= 0; i--) send(bit'((8'hA5 >> i) & 8'd1));
      chk("clamp0_det", 8'(det), 8'd1);
      load(8'h3C, 4'd12, 1'b0);
      for (int i = 7; i >= 0; i--) send(bit'((8'h3C >> i) & 8'd1));
      chk("clamp12_det", 8'(det), 8'd1);

      // Randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         rst      = ($urandom_range(0, 499) == 0);
         en       = ($urandom_range(0, 19) != 0);
         cfg_load = ($urandom_range(0, 59) == 0);
         if (cfg_load) begin
            cfg_pattern = MAX_LEN'($urandom);
            cfg_len     = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15))
                                                      : LEN_W'($urandom_range(1, 4));
            cfg_overlap = 1'($urandom_range(0, 1));
         end
         in_valid = ($urandom_range(0, 3) != 0);
         data_in  = 1'($urandom_range(0, 1));
         cnt_clr  = ($urandom_range(0, 49) == 0);
         tick();
      end
      rst = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
